// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool over a raster pixel stream.
// One line buffer of horizontal maxima; no backpressure.
module maxpool_2x2 #(
  parameter int IN_WIDTH   = 5,
  parameter int IN_HEIGHT  = 5,
  parameter int IN_CHANNEL = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*IN_CHANNEL-1:0] i_data,
  input  logic                             i_valid,
  output logic [DATA_WIDTH*IN_CHANNEL-1:0] o_data,
  output logic                             o_valid,
  output logic                             o_last
);

  localparam int OUT_W = IN_WIDTH / 2;
  localparam int OUT_H = IN_HEIGHT / 2;
  localparam int PW    = DATA_WIDTH * IN_CHANNEL;
  localparam int CW    = $clog2(IN_WIDTH);
  localparam int RW    = $clog2(IN_HEIGHT);
  localparam int LW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] COL_END = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] COL_LIM = CW'(2 * OUT_W - 1);
  localparam logic [RW-1:0] ROW_END = RW'(IN_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LIM = RW'(2 * OUT_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_h;
  logic [PW-1:0] r_lb [OUT_W];
  logic [PW-1:0] r_o_data;
  logic          r_o_valid;
  logic          r_o_last;

  logic [LW-1:0] w_lb_idx;
  logic [PW-1:0] w_lb_rd;
  logic [PW-1:0] w_hmax;
  logic [PW-1:0] w_pool;
  logic          w_in_col;
  logic          w_in_row;
  logic          w_h_wr;
  logic          w_lb_wr;
  logic          w_emit;
  logic          w_last;

  assign w_lb_idx = LW'(r_col >> 1);
  assign w_lb_rd  = r_lb[w_lb_idx];
  assign w_in_col = (r_col <= COL_LIM);
  assign w_in_row = (r_row <= ROW_LIM);

  // Even in-range column loads h; odd column with valid row pools.
  assign w_h_wr  = i_valid && w_in_col && !r_col[0];
  assign w_lb_wr = i_valid && w_in_col && r_col[0]
                   && w_in_row && !r_row[0];
  assign w_emit  = i_valid && w_in_col && r_col[0]
                   && w_in_row && r_row[0];
  assign w_last  = (r_col == COL_LIM) && (r_row == ROW_LIM);

  // Per-channel unsigned max: horizontal pair, then against line buffer.
  for (genvar k = 0; k < IN_CHANNEL; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_m;
    logic [DATA_WIDTH-1:0] w_l;
    assign w_a = r_h[DATA_WIDTH*k +: DATA_WIDTH];
    assign w_b = i_data[DATA_WIDTH*k +: DATA_WIDTH];
    assign w_m = (w_a > w_b) ? w_a : w_b;
    assign w_l = w_lb_rd[DATA_WIDTH*k +: DATA_WIDTH];
    assign w_hmax[DATA_WIDTH*k +: DATA_WIDTH] = w_m;
    assign w_pool[DATA_WIDTH*k +: DATA_WIDTH] = (w_l > w_m) ? w_l : w_m;
  end

  // Raster position counters, hold register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_h       <= '0;
      r_o_data  <= '0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
    end else begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      if (i_valid) begin
        if (r_col == COL_END) begin
          r_col <= '0;
          r_row <= (r_row == ROW_END) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_h_wr) begin
        r_h <= i_data;
      end
      if (w_emit) begin
        r_o_data  <= w_pool;
        r_o_valid <= 1'b1;
        r_o_last  <= w_last;
      end
    end
  end

  // Line buffer: written on even rows before every odd-row read, so no reset.
  always_ff @(posedge clk) begin
    if (w_lb_wr) begin
      r_lb[w_lb_idx] <= w_hmax;
    end
  end

  assign o_data  = r_o_data;
  assign o_valid = r_o_valid;
  assign o_last  = r_o_last;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Testbench for maxpool_2x2: 4x4 and 5x5 instances against a
// frame-level max-pool model, with per-cycle output checking.
module tb_maxpool_2x2;

  logic        clk;
  logic        rst;
  logic        iv [2];
  logic [23:0] id [2];
  logic        ov [2];
  logic [23:0] od [2];
  logic        ol [2];

  int n_chk;
  int n_fail;

  logic [24:0] q [$];
  bit          pend;
  logic [23:0] last_data [2];
  logic [23:0] fr [5][5];

  maxpool_2x2 #(
    .IN_WIDTH (4),
    .IN_HEIGHT(4)
  ) dut4 (
    .clk    (clk),
    .rst    (rst),
    .i_data (id[0]),
    .i_valid(iv[0]),
    .o_data (od[0]),
    .o_valid(ov[0]),
    .o_last (ol[0])
  );

  maxpool_2x2 dut5 (
    .clk    (clk),
    .rst    (rst),
    .i_data (id[1]),
    .i_valid(iv[1]),
    .o_data (od[1]),
    .o_valid(ov[1]),
    .o_last (ol[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mx(input logic [7:0] a,
                                    input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [23:0] pix(input int mode, input int r,
                                      input int c, input int w);
    logic [7:0] v;
    logic [23:0] p;
    v = 8'(r * w + c);
    p = '0;
    case (mode)
      0: p = {v, v, v};
      1: p = {v, 8'h80, 8'(255 - (r * w + c))};
      2: p = 24'($urandom);
      3: for (int k = 0; k < 3; k++)
           p[8*k +: 8] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
      default: p = 24'hF0F0F0 | 24'($urandom_range(0, 15));
    endcase
    return p;
  endfunction

  // One clock: check outputs from the previous edge, then drive a beat.
  task automatic cyc(input int s, input logic v,
                     input logic [23:0] d, input bit trig);
    logic [24:0] e;
    @(negedge clk);
    chk("o_valid", 32'(ov[s]), 32'(pend));
    if (pend) begin
      if (q.size() == 0) begin
        chk("exp_queue", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("o_data", 32'(od[s]), 32'(e[23:0]));
        chk("o_last", 32'(ol[s]), 32'(e[24]));
        last_data[s] = e[23:0];
      end
    end else begin
      chk("o_last_idle", 32'(ol[s]), 32'd0);
      chk("o_data_hold", 32'(od[s]), 32'(last_data[s]));
    end
    pend  = v && trig;
    iv[s] = v;
    id[s] = d;
  endtask

  task automatic drain(input int s, input int n);
    for (int i = 0; i < n; i++) cyc(s, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic run_frame(input int s, input int mode,
                           input bit gaps, input int nbeats);
    int w, h, ow, oh, b;
    logic [23:0] p00, p01, p10, p11;
    logic [24:0] e;
    w  = s ? 5 : 4;
    h  = w;
    ow = w / 2;
    oh = h / 2;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        fr[r][c] = pix(mode, r, c, w);
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        p00 = fr[2*r][2*c];
        p01 = fr[2*r][2*c+1];
        p10 = fr[2*r+1][2*c];
        p11 = fr[2*r+1][2*c+1];
        e = '0;
        for (int k = 0; k < 3; k++)
          e[8*k +: 8] = mx(mx(p00[8*k +: 8], p01[8*k +: 8]),
                           mx(p10[8*k +: 8], p11[8*k +: 8]));
        e[24] = (r == oh - 1) && (c == ow - 1);
        q.push_back(e);
      end
    b = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (b < nbeats) begin
          if (gaps) drain(s, $urandom_range(1, 5));
          cyc(s, 1'b1, fr[r][c],
              (r % 2 == 1) && (c % 2 == 1) &&
              (r < 2 * oh) && (c < 2 * ow));
        end
        b++;
      end
  endtask

  task automatic leftover();
    chk("leftover", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0;
      id[s] = '0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("rst_valid", 32'(ov[s]), 32'd0);
        chk("rst_last", 32'(ol[s]), 32'd0);
        chk("rst_data", 32'(od[s]), 32'd0);
      end
    end
    rst  = 1'b0;
    pend = 1'b0;
    q.delete();
    last_data[0] = '0;
    last_data[1] = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    pend   = 1'b0;
    rst    = 1'b1;
    do_reset();

    // 4x4 ramp, continuous
    run_frame(0, 0, 1'b0, 16);
    drain(0, 3);
    leftover();

    // 5x5 ramp then random frame straight after (4,4)
    run_frame(1, 0, 1'b0, 25);
    run_frame(1, 2, 1'b0, 25);
    drain(1, 3);
    leftover();

    // channel independence and unsigned 0x80/0x7F compare
    run_frame(0, 1, 1'b0, 16);
    run_frame(0, 3, 1'b0, 16);
    drain(0, 3);
    leftover();

    // ramp with random idle gaps
    run_frame(0, 0, 1'b1, 16);
    drain(0, 3);
    leftover();

    // back-to-back: large values then small ramp
    run_frame(0, 4, 1'b0, 16);
    run_frame(0, 0, 1'b0, 16);
    drain(0, 3);
    leftover();

    // partial frame, reset, then replay
    run_frame(0, 0, 1'b0, 7);
    do_reset();
    run_frame(0, 0, 1'b0, 16);
    drain(0, 3);
    leftover();

    // random frames with gaps on both sizes
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 2, 1'b1, 16);
      drain(0, 2);
      run_frame(1, 2, (i % 2) == 1, 25);
      drain(1, 2);
      leftover();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
